// File: rtl/fwd_result_pipe.sv
// EX/MEM and MEM/WB result registers with forwarding taps, load-data merge,
// register-file writeback port and a saturating retired-write counter.
module fwd_result_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] mem_rdata,
  input  logic        mem_hold,
  input  logic        ex_flush,
  output logic [4:0]  EX_MEM_Rd,
  output logic        EX_MEM_RegWrite,
  output logic [4:0]  MEM_WB_Rd,
  output logic        MEM_WB_RegWrite,
  output logic [31:0] EX_MEM_Data,
  output logic [31:0] MEM_WB_Data,
  output logic        EX_MEM_Load,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [15:0] wb_count
);

  logic ex_mem_memread;
  logic ex_bubble;

  assign ex_bubble = ~ex_valid | ex_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      EX_MEM_Rd       <= '0;
      EX_MEM_RegWrite <= 1'b0;
      EX_MEM_Data     <= '0;
      ex_mem_memread  <= 1'b0;
      MEM_WB_Rd       <= '0;
      MEM_WB_RegWrite <= 1'b0;
      MEM_WB_Data     <= '0;
    end else if (!mem_hold) begin
      if (ex_bubble) begin
        EX_MEM_Rd       <= '0;
        EX_MEM_RegWrite <= 1'b0;
        EX_MEM_Data     <= '0;
        ex_mem_memread  <= 1'b0;
      end else begin
        EX_MEM_Rd       <= ex_rd;
        EX_MEM_RegWrite <= ex_regwrite & (ex_rd != 5'd0);
        EX_MEM_Data     <= ex_alu_result;
        ex_mem_memread  <= ex_memread;
      end
      // Load data arrives while the load sits in EX/MEM; merge it on the way out.
      MEM_WB_Rd       <= EX_MEM_Rd;
      MEM_WB_RegWrite <= EX_MEM_RegWrite;
      MEM_WB_Data     <= ex_mem_memread ? mem_rdata : EX_MEM_Data;
    end
  end

  assign EX_MEM_Load = ex_mem_memread & EX_MEM_RegWrite;

  assign wb_we   = MEM_WB_RegWrite & ~mem_hold;
  assign wb_addr = MEM_WB_Rd;
  assign wb_data = MEM_WB_Data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_count <= '0;
    end else if (wb_we && (wb_count != 16'hFFFF)) begin
      wb_count <= wb_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Directed scenarios followed by randomized traffic checked against an
// instruction-level model of the two result stages.
module tb_fwd_result_pipe;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [31:0] ex_alu_result;
  logic [31:0] mem_rdata;
  logic        mem_hold;
  logic        ex_flush;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_RegWrite;
  logic [4:0]  MEM_WB_Rd;
  logic        MEM_WB_RegWrite;
  logic [31:0] EX_MEM_Data;
  logic [31:0] MEM_WB_Data;
  logic        EX_MEM_Load;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [15:0] wb_count;

  int n_assert = 0;
  int n_fail   = 0;

  fwd_result_pipe dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_alu_result(ex_alu_result), .mem_rdata(mem_rdata),
    .mem_hold(mem_hold), .ex_flush(ex_flush),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .EX_MEM_Data(EX_MEM_Data), .MEM_WB_Data(MEM_WB_Data),
    .EX_MEM_Load(EX_MEM_Load), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic hold, input logic flush, input logic rst);
    ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memread = mr;
    ex_alu_result = alu; mem_rdata = rdata; mem_hold = hold; ex_flush = flush;
    reset = rst;
    #1;
  endtask

  task automatic idle(input logic [31:0] rdata);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, rdata, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One in-flight instruction awaiting writeback, and one already resolved.
  typedef struct packed {
    logic        writes;
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] alu;
  } instr_t;

  typedef struct packed {
    logic        writes;
    logic [4:0]  rd;
    logic [31:0] data;
  } retire_t;

  initial begin
    instr_t  in_mem;
    retire_t in_wb;
    int      exp_cnt;
    logic    v, rw, mr, hold, flush;
    logic [4:0]  rd;
    logic [31:0] alu, rdata;

    drive(1'b1, 5'd9, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    chk("rst_exm_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("rst_exm_data", EX_MEM_Data, 32'd0);
    chk("rst_mwb_rd", {27'd0, MEM_WB_Rd}, 32'd0);
    chk("rst_wb_cnt", {16'd0, wb_count}, 32'd0);

    // ALU result through both stages
    drive(1'b1, 5'd5, 1'b1, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle(32'h0);
    chk("alu_exm_rd", {27'd0, EX_MEM_Rd}, 32'd5);
    chk("alu_exm_rw", {31'd0, EX_MEM_RegWrite}, 32'd1);
    chk("alu_exm_data", EX_MEM_Data, 32'h1234);
    chk("alu_exm_load", {31'd0, EX_MEM_Load}, 32'd0);
    tick();
    chk("alu_mwb_data", MEM_WB_Data, 32'h1234);
    chk("alu_wb_we", {31'd0, wb_we}, 32'd1);
    chk("alu_wb_addr", {27'd0, wb_addr}, 32'd5);
    chk("alu_cnt_before", {16'd0, wb_count}, 32'd0);
    tick();
    chk("alu_cnt_after", {16'd0, wb_count}, 32'd1);
    chk("alu_we_once", {31'd0, wb_we}, 32'd0);

    // Load: data comes from mem_rdata, not the ALU value
    drive(1'b1, 5'd7, 1'b1, 1'b1, 32'hDEAD_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle(32'hCAFE);
    chk("ld_exm_load", {31'd0, EX_MEM_Load}, 32'd1);
    tick();
    idle(32'h0);
    chk("ld_mwb_data", MEM_WB_Data, 32'hCAFE);
    chk("ld_wb_addr", {27'd0, wb_addr}, 32'd7);
    chk("ld_wb_we", {31'd0, wb_we}, 32'd1);
    tick();
    chk("ld_cnt", {16'd0, wb_count}, 32'd2);

    // r0 destination never writes
    drive(1'b1, 5'd0, 1'b1, 1'b0, 32'h55, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle(32'h0);
    chk("r0_exm_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    tick();
    chk("r0_mwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
    chk("r0_wb_we", {31'd0, wb_we}, 32'd0);
    tick();
    chk("r0_cnt", {16'd0, wb_count}, 32'd2);

    // Flush turns a valid write into a bubble
    drive(1'b1, 5'd9, 1'b1, 1'b1, 32'h99, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    idle(32'h0);
    chk("fl_exm_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("fl_exm_rd", {27'd0, EX_MEM_Rd}, 32'd0);
    chk("fl_exm_load", {31'd0, EX_MEM_Load}, 32'd0);
    tick();
    chk("fl_mwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
    chk("fl_wb_we", {31'd0, wb_we}, 32'd0);
    tick();
    chk("fl_cnt", {16'd0, wb_count}, 32'd2);

    // Hold freezes both stages for three cycles; flush ignored meanwhile
    drive(1'b1, 5'd3, 1'b1, 1'b0, 32'h333, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 32'h444, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd9, 1'b1, 1'b0, 32'h999, 32'hBAD, 1'b1, 1'b1, 1'b0);
      chk("hold_wb_we", {31'd0, wb_we}, 32'd0);
      chk("hold_exm_rd", {27'd0, EX_MEM_Rd}, 32'd4);
      chk("hold_exm_data", EX_MEM_Data, 32'h444);
      chk("hold_mwb_rd", {27'd0, MEM_WB_Rd}, 32'd3);
      chk("hold_mwb_data", MEM_WB_Data, 32'h333);
      tick();
    end
    idle(32'h0);
    chk("hold_cnt_frozen", {16'd0, wb_count}, 32'd2);
    chk("rel_r3_we", {31'd0, wb_we}, 32'd1);
    chk("rel_r3_addr", {27'd0, wb_addr}, 32'd3);
    tick();
    chk("rel_r4_we", {31'd0, wb_we}, 32'd1);
    chk("rel_r4_addr", {27'd0, wb_addr}, 32'd4);
    chk("rel_r4_data", wb_data, 32'h444);
    chk("rel_cnt1", {16'd0, wb_count}, 32'd3);
    tick();
    chk("rel_done_we", {31'd0, wb_we}, 32'd0);
    chk("rel_cnt2", {16'd0, wb_count}, 32'd4);

    // Reset wins over hold with both stages full
    drive(1'b1, 5'd3, 1'b1, 1'b0, 32'h333, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 1'b1, 32'h444, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 1'b1, 32'h666, 32'h0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rr_exm_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("rr_exm_rd", {27'd0, EX_MEM_Rd}, 32'd0);
    chk("rr_exm_load", {31'd0, EX_MEM_Load}, 32'd0);
    chk("rr_mwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
    chk("rr_mwb_data", MEM_WB_Data, 32'd0);
    chk("rr_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rr_cnt", {16'd0, wb_count}, 32'd0);

    // Randomized traffic against the instruction-level model
    in_mem  = '0;
    in_wb   = '0;
    exp_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      v     = ($urandom_range(0, 9) < 8);
      rd    = 5'($urandom_range(0, 7));
      rw    = ($urandom_range(0, 3) != 0);
      mr    = ($urandom_range(0, 2) == 0);
      alu   = $urandom;
      rdata = $urandom;
      hold  = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 6) == 0);
      drive(v, rd, rw, mr, alu, rdata, hold, flush, 1'b0);

      chk("r_exm_rw", {31'd0, EX_MEM_RegWrite}, {31'd0, in_mem.writes});
      chk("r_exm_rd", {27'd0, EX_MEM_Rd}, {27'd0, in_mem.rd});
      chk("r_exm_load", {31'd0, EX_MEM_Load}, {31'd0, in_mem.writes & in_mem.is_load});
      chk("r_exm_data", EX_MEM_Data, in_mem.alu);
      chk("r_mwb_rw", {31'd0, MEM_WB_RegWrite}, {31'd0, in_wb.writes});
      chk("r_mwb_rd", {27'd0, MEM_WB_Rd}, {27'd0, in_wb.rd});
      chk("r_wb_we", {31'd0, wb_we}, {31'd0, in_wb.writes & ~hold});
      if (in_wb.writes) begin
        chk("r_wb_addr", {27'd0, wb_addr}, {27'd0, in_wb.rd});
        chk("r_wb_data", wb_data, in_wb.data);
      end
      chk("r_wb_cnt", {16'd0, wb_count}, exp_cnt);

      if (in_wb.writes && !hold && exp_cnt < 65535) exp_cnt++;
      if (!hold) begin
        in_wb.writes = in_mem.writes;
        in_wb.rd     = in_mem.rd;
        in_wb.data   = in_mem.is_load ? rdata : in_mem.alu;
        if (!v || flush) in_mem = '0;
        else begin
          in_mem.writes  = rw && (rd != 5'd0);
          in_mem.rd      = rd;
          in_mem.is_load = mr;
          in_mem.alu     = alu;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_result_pipe.md
FWD_RESULT_PIPE -- requirements
Module: fwd_result_pipe

Interface
REQ-001 SHALL have no parameters; all widths fixed (5-bit register index, 32-bit data).
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Port ex_valid  in  1  EX stage holds a real instruction this cycle.
REQ-005 Port ex_rd  in  5  EX-stage destination register.
REQ-006 Port ex_regwrite  in  1  EX-stage instruction writes a register.
REQ-007 Port ex_memread  in  1  EX-stage instruction is a load.
REQ-008 Port ex_alu_result  in  32  EX-stage ALU result.
REQ-009 Port mem_rdata  in  32  data-memory read data for the instruction currently in EX/MEM.
REQ-010 Port mem_hold  in  1  memory not ready; freeze EX/MEM and MEM/WB.
REQ-011 Port ex_flush  in  1  replace the EX-stage instruction with a bubble.
REQ-012 Port EX_MEM_Rd / EX_MEM_RegWrite  out  5 / 1  EX/MEM destination and write-enable, feeding the forwarding unit.
REQ-013 Port MEM_WB_Rd / MEM_WB_RegWrite  out  5 / 1  MEM/WB destination and write-enable, feeding the forwarding unit.
REQ-014 Port EX_MEM_Data  out  32  value forwarded on code 01 (EX/MEM ALU result).
REQ-015 Port MEM_WB_Data  out  32  value forwarded on code 10 (load data or ALU result).
REQ-016 Port EX_MEM_Load  out  1  EX/MEM holds a load; EX_MEM_Data invalid for forwarding.
REQ-017 Port wb_we / wb_addr / wb_data  out  1 / 5 / 32  register-file write port.
REQ-018 Port wb_count  out  16  count of retired register writes.

Function
REQ-019 EX/MEM capture: on each edge with mem_hold=0, load ex_rd, ex_alu_result, ex_memread, and RegWrite = ex_regwrite & ex_valid & ~ex_flush & (ex_rd!=0).
REQ-020 Bubble: if ex_valid=0 or ex_flush=1, EX/MEM RegWrite=0, Load=0, Rd=0, Data=0.
REQ-021 MEM/WB capture: on each edge with mem_hold=0, copy EX/MEM Rd and RegWrite; MEM_WB_Data = mem_rdata if EX/MEM Load=1, else EX/MEM Data.
REQ-022 mem_hold=1: both register sets keep their values; ex_flush ignored that cycle; wb_we forced 0.
REQ-023 Writeback: wb_we = MEM_WB_RegWrite & ~mem_hold; wb_addr = MEM_WB_Rd; wb_data = MEM_WB_Data; combinational from MEM/WB state.
REQ-024 Latency: EX-stage instruction at edge N appears in EX/MEM after edge N, in MEM/WB after edge N+1; wb_we asserted during cycle N+1..N+2 (one cycle, absent hold).
REQ-025 Each MEM/WB entry retires exactly once: wb_we high for exactly one non-hold cycle per entry.
REQ-026 wb_count increments by 1 on each edge where wb_we=1; saturates at 16'hFFFF.
REQ-027 EX_MEM_Load = EX/MEM Load & EX_MEM_RegWrite; used by hazard logic to stall on load-use.
REQ-028 Rd=0 writes never assert any RegWrite output or wb_we.
REQ-029 All outputs are registered or a direct function of registered state plus mem_hold; no path from ex_* inputs to outputs.

Reset
REQ-030 reset=1 at an edge clears all EX/MEM and MEM/WB fields, Load and wb_count to 0; takes priority over mem_hold and ex_flush.
REQ-031 While reset is held, all outputs read 0; the first capture occurs on the first edge with reset=0.

Verification
REQ-032 ALU op ex_rd=5, regwrite=1, result=32'h1234 at edge 0 -> cycle 1: EX_MEM_Rd=5, RegWrite=1, Data=32'h1234; cycle 2: MEM_WB_Data=32'h1234, wb_we=1, wb_addr=5; wb_count=1 after edge 2.
REQ-033 Load ex_rd=7, memread=1, mem_rdata=32'hCAFE in cycle 1 -> cycle 1 EX_MEM_Load=1; cycle 2 MEM_WB_Data=32'hCAFE, wb_addr=7.
REQ-034 ex_rd=0, regwrite=1 -> EX_MEM_RegWrite, MEM_WB_RegWrite, wb_we stay 0; wb_count unchanged.
REQ-035 ex_flush=1 on valid write to r9 -> bubble: no RegWrite in either stage, no writeback.
REQ-036 mem_hold=1 for 3 cycles with writes to r3 (MEM/WB) and r4 (EX/MEM) -> all outputs frozen, wb_we=0; after release r3 retires once, then r4 retires once; wb_count +2 total.
REQ-037 reset asserted while both stages hold writes and mem_hold=1 -> next cycle all outputs 0, wb_count=0.
